// File: rtl/nubus_master_engine_pkg.sv
// Shared NuBus transfer-type and acknowledge encodings for the master engine.
// TM/AD codes are true polarity as {TM1, TM0, AD1, AD0}.
package nubus_master_engine_pkg;

   localparam logic [3:0] TMAD_WR_BYTE_0 = 4'b1100;
   localparam logic [3:0] TMAD_WR_BYTE_1 = 4'b1101;
   localparam logic [3:0] TMAD_WR_BYTE_2 = 4'b1110;
   localparam logic [3:0] TMAD_WR_BYTE_3 = 4'b1111;
   localparam logic [3:0] TMAD_WR_HALF_0 = 4'b1000;
   localparam logic [3:0] TMAD_WR_HALF_1 = 4'b1010;
   localparam logic [3:0] TMAD_WR_WORD   = 4'b1011;
   localparam logic [3:0] TMAD_RD_WORD   = 4'b0011;

   localparam logic [1:0] TMACK_COMPLETE = 2'b00;
   localparam logic [1:0] TMACK_ERROR    = 2'b01;
   localparam logic [1:0] TMACK_TIMEOUT  = 2'b10;
   localparam logic [1:0] TMACK_TRYAGAIN = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_START,
      S_DATA,
      S_DONE
   } state_t;

   // Returns {legal, tmad}; any strobe pattern that is not a byte, an
   // aligned half or a full word comes back with legal = 0.
   function automatic logic [4:0] wstrb_to_tmad(input logic [3:0] wstrb);
      case (wstrb)
         4'b0000: return {1'b1, TMAD_RD_WORD};
         4'b1111: return {1'b1, TMAD_WR_WORD};
         4'b0011: return {1'b1, TMAD_WR_HALF_0};
         4'b1100: return {1'b1, TMAD_WR_HALF_1};
         4'b0001: return {1'b1, TMAD_WR_BYTE_0};
         4'b0010: return {1'b1, TMAD_WR_BYTE_1};
         4'b0100: return {1'b1, TMAD_WR_BYTE_2};
         4'b1000: return {1'b1, TMAD_WR_BYTE_3};
         default: return 5'b0_0000;
      endcase
   endfunction

endpackage

// File: rtl/nubus_master_engine.sv
// NuBus initiator: turns one CPU valid/ready request into a single bus transfer,
// with arbitration request, timeout, try-again retries and locked ownership.
module nubus_master_engine
   import nubus_master_engine_pkg::*;
#(
   parameter int TIMEOUT_CLOCKS = 255,
   parameter int RETRY_MAX      = 3
) (
   input  logic        nub_clkn,
   input  logic        nub_resetn,
   input  logic        cpu_valid,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_wstrb,
   input  logic        cpu_lock,
   output logic        cpu_ready,
   output logic [31:0] cpu_rdata,
   output logic [1:0]  cpu_status,
   output logic        arb_rqst,
   input  logic        arb_grant,
   input  logic        nub_startn_i,
   input  logic        nub_ackn_i,
   input  logic [1:0]  nub_tm_i,
   input  logic [31:0] nub_ad_i,
   output logic        nub_startn_o,
   output logic [1:0]  nub_tm_o,
   output logic        nub_tm_oe,
   output logic [31:0] nub_ad_o,
   output logic        nub_ad_oe
);

   localparam int TW = $clog2(TIMEOUT_CLOCKS + 1);
   localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

   state_t        state_q, state_n;
   logic [31:2]   addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    tmad_q;
   logic          lock_q;
   logic          owned_q;
   logic          drop_q;
   logic [RW-1:0] retry_q;
   logic [TW-1:0] tcnt_q;
   logic [31:0]   rdata_q;
   logic [1:0]    status_q;

   logic [4:0]    dec;
   logic          ack;
   logic          is_write;
   logic          timeout_hit;
   logic          retry_ok;
   logic          unused_addr;

   assign dec         = wstrb_to_tmad(cpu_wstrb);
   assign ack         = !nub_ackn_i;
   assign is_write    = tmad_q[3];
   assign timeout_hit = (tcnt_q == TW'(TIMEOUT_CLOCKS - 1));
   assign retry_ok    = (nub_tm_i == TMACK_TRYAGAIN) && (retry_q < RW'(RETRY_MAX));
   assign unused_addr = ^cpu_addr[1:0];

   assign cpu_rdata  = rdata_q;
   assign cpu_status = status_q;

   always_comb begin
      state_n      = state_q;
      cpu_ready    = 1'b0;
      arb_rqst     = 1'b0;
      nub_startn_o = 1'b1;
      nub_tm_o     = 2'b00;
      nub_tm_oe    = 1'b0;
      nub_ad_o     = 32'h0;
      nub_ad_oe    = 1'b0;
      case (state_q)
         S_IDLE: begin
            arb_rqst = owned_q;
            if (cpu_valid) begin
               if (!dec[4])      state_n = S_DONE;
               else if (owned_q) state_n = S_START;
               else              state_n = S_ARB;
            end
         end
         S_ARB: begin
            // drop_q gives the arbiter one cycle of released request after try-again
            arb_rqst = !drop_q;
            if (!drop_q && arb_grant && nub_startn_i && nub_ackn_i)
               state_n = S_START;
         end
         S_START: begin
            arb_rqst     = lock_q;
            nub_startn_o = 1'b0;
            nub_ad_o     = {addr_q, tmad_q[1:0]};
            nub_ad_oe    = 1'b1;
            nub_tm_o     = tmad_q[3:2];
            nub_tm_oe    = 1'b1;
            state_n      = S_DATA;
         end
         S_DATA: begin
            arb_rqst = lock_q;
            if (is_write) begin
               nub_ad_o  = wdata_q;
               nub_ad_oe = 1'b1;
            end
            if (ack)              state_n = retry_ok ? S_ARB : S_DONE;
            else if (timeout_hit) state_n = S_DONE;
         end
         S_DONE: begin
            cpu_ready = 1'b1;
            arb_rqst  = lock_q;
            state_n   = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge nub_clkn) begin
      if (!nub_resetn) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         tmad_q   <= '0;
         lock_q   <= 1'b0;
         owned_q  <= 1'b0;
         drop_q   <= 1'b0;
         retry_q  <= '0;
         tcnt_q   <= '0;
         rdata_q  <= '0;
         status_q <= TMACK_COMPLETE;
      end else begin
         state_q <= state_n;
         drop_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cpu_valid) begin
                  retry_q <= '0;
                  if (dec[4]) begin
                     addr_q  <= cpu_addr[31:2];
                     wdata_q <= cpu_wdata;
                     tmad_q  <= dec[3:0];
                     lock_q  <= cpu_lock;
                  end else begin
                     // an illegal request never touches the bus, so it can keep but not gain ownership
                     status_q <= TMACK_ERROR;
                     lock_q   <= cpu_lock & owned_q;
                  end
               end
            end
            S_START: tcnt_q <= '0;
            S_DATA: begin
               if (ack) begin
                  if (retry_ok) begin
                     retry_q <= retry_q + RW'(1);
                     drop_q  <= 1'b1;
                  end else begin
                     status_q <= nub_tm_i;
                     if (!is_write) rdata_q <= nub_ad_i;
                  end
               end else if (timeout_hit) begin
                  status_q <= TMACK_TIMEOUT;
                  lock_q   <= 1'b0;
               end else if (tcnt_q != TW'(TIMEOUT_CLOCKS)) begin
                  tcnt_q <= tcnt_q + TW'(1);
               end
            end
            S_DONE: owned_q <= lock_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nubus_master_engine.sv
// Directed bench for nubus_master_engine: a cycle-stepped responder plays the
// arbiter and slave while each scenario task checks its own results.
module tb_nubus_master_engine;
   import nubus_master_engine_pkg::*;

   logic        nub_clkn = 1'b0;
   logic        nub_resetn;
   logic        valid, sel;
   logic        valid_a, valid_b;
   logic [31:0] cpu_addr, cpu_wdata, nub_ad_i;
   logic [3:0]  cpu_wstrb;
   logic        cpu_lock, arb_grant, nub_startn_i, nub_ackn_i;
   logic [1:0]  nub_tm_i;

   logic        a_ready, a_rqst, a_startn, a_tm_oe, a_ad_oe;
   logic [31:0] a_rdata, a_ad_o;
   logic [1:0]  a_status, a_tm_o;
   logic        b_ready, b_rqst, b_startn, b_tm_oe, b_ad_oe;
   logic [31:0] b_rdata, b_ad_o;
   logic [1:0]  b_status, b_tm_o;

   logic        m_ready, m_rqst, m_startn, m_tm_oe, m_ad_oe;
   logic [31:0] m_rdata, m_ad_o;
   logic [1:0]  m_status, m_tm_o;

   int checks = 0;
   int fails  = 0;

   int          lat, starts, start_cyc;
   logic [31:0] st_ad, d_ad, r_rdata;
   logic [1:0]  st_tm, r_status;
   logic        d_adoe, d_tmoe, rq1, r_rqst;

   always #5 nub_clkn = ~nub_clkn;

   assign valid_a  = valid && !sel;
   assign valid_b  = valid && sel;
   assign m_ready  = sel ? b_ready  : a_ready;
   assign m_rqst   = sel ? b_rqst   : a_rqst;
   assign m_startn = sel ? b_startn : a_startn;
   assign m_tm_oe  = sel ? b_tm_oe  : a_tm_oe;
   assign m_ad_oe  = sel ? b_ad_oe  : a_ad_oe;
   assign m_rdata  = sel ? b_rdata  : a_rdata;
   assign m_ad_o   = sel ? b_ad_o   : a_ad_o;
   assign m_status = sel ? b_status : a_status;
   assign m_tm_o   = sel ? b_tm_o   : a_tm_o;

   nubus_master_engine #(.TIMEOUT_CLOCKS(255), .RETRY_MAX(3)) dut (
      .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .cpu_valid(valid_a),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
      .cpu_lock(cpu_lock), .cpu_ready(a_ready), .cpu_rdata(a_rdata),
      .cpu_status(a_status), .arb_rqst(a_rqst), .arb_grant(arb_grant),
      .nub_startn_i(nub_startn_i), .nub_ackn_i(nub_ackn_i), .nub_tm_i(nub_tm_i),
      .nub_ad_i(nub_ad_i), .nub_startn_o(a_startn), .nub_tm_o(a_tm_o),
      .nub_tm_oe(a_tm_oe), .nub_ad_o(a_ad_o), .nub_ad_oe(a_ad_oe));

   nubus_master_engine #(.TIMEOUT_CLOCKS(255), .RETRY_MAX(0)) dut_r0 (
      .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .cpu_valid(valid_b),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
      .cpu_lock(cpu_lock), .cpu_ready(b_ready), .cpu_rdata(b_rdata),
      .cpu_status(b_status), .arb_rqst(b_rqst), .arb_grant(arb_grant),
      .nub_startn_i(nub_startn_i), .nub_ackn_i(nub_ackn_i), .nub_tm_i(nub_tm_i),
      .nub_ad_i(nub_ad_i), .nub_startn_o(b_startn), .nub_tm_o(b_tm_o),
      .nub_tm_oe(b_tm_oe), .nub_ad_o(b_ad_o), .nub_ad_oe(b_ad_oe));

   // Runs one request; the slave ACKs on data cycle ack_at (0 = never),
   // answering TRYAGAIN for the first ntry attempts and fin_tm afterwards.
   task automatic do_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic lk, input logic gnt, input int ack_at, input int ntry,
                          input logic [1:0] fin_tm, input logic [31:0] resp);
      int  dn, att;
      logic in_data;
      cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws; cpu_lock = lk; arb_grant = gnt;
      valid = 1'b1;
      starts = 0; lat = -1; start_cyc = -1; dn = 0; att = 0; in_data = 1'b0;
      for (int c = 1; c <= 2000 && lat < 0; c++) begin
         @(posedge nub_clkn); #1;
         nub_ackn_i = 1'b1; nub_tm_i = 2'b00; nub_ad_i = 32'h0;
         if (c == 1) rq1 = m_rqst;
         if (m_ready) begin
            lat = c; r_status = m_status; r_rdata = m_rdata; r_rqst = m_rqst;
            valid = 1'b0;
         end else if (!m_startn) begin
            starts++; start_cyc = c; st_ad = m_ad_o; st_tm = m_tm_o;
            in_data = 1'b1; dn = 0;
         end else if (in_data) begin
            dn++;
            if (dn == 1) begin d_ad = m_ad_o; d_adoe = m_ad_oe; d_tmoe = m_tm_oe; end
            if (dn == ack_at) begin
               nub_ackn_i = 1'b0;
               nub_tm_i   = (att < ntry) ? TMACK_TRYAGAIN : fin_tm;
               nub_ad_i   = resp;
               in_data    = 1'b0;
               att++;
            end
         end
      end
      if (lat < 0) begin
         checks++; fails++;
         $display("FAIL xfer_bound: no cpu_ready within 2000 cycles (addr %h)", a);
         valid = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge nub_clkn); #1;
   endtask

   task automatic test_reset();
      nub_resetn = 1'b0; tick(); tick(); nub_resetn = 1'b1; #1;
      checks++; if ({m_ready, m_rqst, m_startn, m_tm_oe, m_ad_oe} !== 5'b00100) begin fails++;
         $display("FAIL reset_ctrl: got %b want 00100", {m_ready, m_rqst, m_startn, m_tm_oe, m_ad_oe}); end
      checks++; if ({m_rdata, m_ad_o, m_tm_o, m_status} !== 68'h0) begin fails++;
         $display("FAIL reset_data: rdata %h ad %h tm %b status %b want zeros", m_rdata, m_ad_o, m_tm_o, m_status); end
   endtask

   task automatic test_word_write();
      do_xfer(32'hF000_0000, 32'h8765_4321, 4'b1111, 1'b0, 1'b1, 6, 0, TMACK_COMPLETE, 32'h0);
      checks++; if (st_ad !== 32'hF000_0003) begin fails++; $display("FAIL ww_start_ad: got %h want F0000003", st_ad); end
      checks++; if (st_tm !== 2'b10) begin fails++; $display("FAIL ww_start_tm: got %b want 10", st_tm); end
      checks++; if ({d_ad, d_adoe, d_tmoe} !== {32'h8765_4321, 1'b1, 1'b0}) begin fails++;
         $display("FAIL ww_data: ad %h oe %b tm_oe %b want 87654321 1 0", d_ad, d_adoe, d_tmoe); end
      checks++; if (lat !== 9) begin fails++; $display("FAIL ww_latency: got %0d want 9", lat); end
      checks++; if (r_status !== TMACK_COMPLETE) begin fails++; $display("FAIL ww_status: got %b want 00", r_status); end
      tick();
      checks++; if (m_ready !== 1'b0) begin fails++; $display("FAIL ww_ready_pulse: got %b want 0", m_ready); end
   endtask

   task automatic test_word_read();
      do_xfer(32'hF000_0004, 32'h0, 4'b0000, 1'b0, 1'b1, 2, 0, TMACK_COMPLETE, 32'h1122_3344);
      checks++; if ({st_ad, st_tm} !== {32'hF000_0007, 2'b00}) begin fails++;
         $display("FAIL rd_start: ad %h tm %b want F0000007 00", st_ad, st_tm); end
      checks++; if (d_adoe !== 1'b0) begin fails++; $display("FAIL rd_ad_oe: got %b want 0", d_adoe); end
      checks++; if (r_rdata !== 32'h1122_3344) begin fails++; $display("FAIL rd_data: got %h want 11223344", r_rdata); end
      checks++; if (lat !== 5) begin fails++; $display("FAIL rd_latency: got %0d want 5", lat); end
      tick();
   endtask

   task automatic test_strobes();
      logic [3:0] ws [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100};
      logic [3:0] tm [6] = '{4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b1000, 4'b1010};
      for (int i = 0; i < 6; i++) begin
         do_xfer(32'h1000_0010, 32'hA5A5_0000 + i, ws[i], 1'b0, 1'b1, 1, 0, TMACK_COMPLETE, 32'hDEAD_BEEF);
         checks++; if ({st_tm, st_ad[1:0]} !== tm[i]) begin fails++;
            $display("FAIL strobe_%b: tmad %b want %b", ws[i], {st_tm, st_ad[1:0]}, tm[i]); end
         if (i == 0) begin
            checks++; if (r_rdata !== 32'h1122_3344) begin fails++;
               $display("FAIL wr_rdata_hold: got %h want 11223344", r_rdata); end
         end
         tick();
      end
      do_xfer(32'h1000_0010, 32'h0, 4'b0101, 1'b0, 1'b1, 1, 0, TMACK_COMPLETE, 32'h0);
      checks++; if ({starts, lat} !== {32'd0, 32'd1}) begin fails++;
         $display("FAIL illegal_strobe: starts %0d latency %0d want 0 1", starts, lat); end
      checks++; if (r_status !== TMACK_ERROR) begin fails++; $display("FAIL illegal_status: got %b want 01", r_status); end
      tick();
   endtask

   task automatic test_timeout();
      do_xfer(32'h2000_0000, 32'h1234_5678, 4'b1111, 1'b0, 1'b1, 0, 0, TMACK_COMPLETE, 32'h0);
      checks++; if (lat - start_cyc !== 256) begin fails++;
         $display("FAIL timeout_delay: got %0d want 256", lat - start_cyc); end
      checks++; if (r_status !== TMACK_TIMEOUT) begin fails++; $display("FAIL timeout_status: got %b want 10", r_status); end
      tick();
      checks++; if ({m_ad_oe, m_tm_oe, m_rqst, m_startn} !== 4'b0001) begin fails++;
         $display("FAIL timeout_release: got %b want 0001", {m_ad_oe, m_tm_oe, m_rqst, m_startn}); end
   endtask

   task automatic test_retry();
      do_xfer(32'h3000_0000, 32'h0, 4'b0000, 1'b0, 1'b1, 1, 2, TMACK_COMPLETE, 32'h5566_7788);
      checks++; if ({starts, lat} !== {32'd3, 32'd12}) begin fails++;
         $display("FAIL retry_two: starts %0d latency %0d want 3 12", starts, lat); end
      checks++; if ({r_status, r_rdata} !== {TMACK_COMPLETE, 32'h5566_7788}) begin fails++;
         $display("FAIL retry_result: status %b rdata %h want 00 55667788", r_status, r_rdata); end
      tick();
      sel = 1'b1;
      do_xfer(32'h3000_0000, 32'h0, 4'b0000, 1'b0, 1'b1, 1, 1, TMACK_COMPLETE, 32'h0);
      checks++; if ({starts, lat} !== {32'd1, 32'd4}) begin fails++;
         $display("FAIL retry_max0_timing: starts %0d latency %0d want 1 4", starts, lat); end
      checks++; if (r_status !== TMACK_TRYAGAIN) begin fails++; $display("FAIL retry_max0_status: got %b want 11", r_status); end
      tick();
      sel = 1'b0;
   endtask

   task automatic test_back_to_back_lock();
      do_xfer(32'h4000_0000, 32'h0, 4'b0000, 1'b1, 1'b1, 1, 0, TMACK_COMPLETE, 32'hAABB_CCDD);
      checks++; if ({r_rqst, r_rdata} !== {1'b1, 32'hAABB_CCDD}) begin fails++;
         $display("FAIL lock_first: rqst %b rdata %h want 1 AABBCCDD", r_rqst, r_rdata); end
      // grant withheld: only a transfer that skips ARB can reach START
      do_xfer(32'h4000_0008, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b0, 1, 0, TMACK_COMPLETE, 32'h0);
      checks++; if (rq1 !== 1'b1) begin fails++; $display("FAIL lock_rqst_held: got %b want 1", rq1); end
      checks++; if ({start_cyc, lat} !== {32'd2, 32'd4}) begin fails++;
         $display("FAIL lock_no_arb: start %0d latency %0d want 2 4", start_cyc, lat); end
      tick();
      checks++; if (m_rqst !== 1'b0) begin fails++; $display("FAIL lock_release: got %b want 0", m_rqst); end
      arb_grant = 1'b1;
   endtask

   task automatic test_reset_mid_data();
      int seen;
      cpu_addr = 32'h5000_0000; cpu_wdata = 32'h0F0F_0F0F; cpu_wstrb = 4'b1111; cpu_lock = 1'b1;
      arb_grant = 1'b1; valid = 1'b1; seen = 0;
      for (int c = 0; c < 20 && seen == 0; c++) begin tick(); if (!m_startn) seen = 1; end
      tick();
      valid = 1'b0; nub_resetn = 1'b0;
      tick();
      checks++; if ({seen[0], m_ready, m_rqst, m_startn, m_tm_oe, m_ad_oe} !== 6'b100100) begin fails++;
         $display("FAIL midreset_ctrl: got %b want 100100", {seen[0], m_ready, m_rqst, m_startn, m_tm_oe, m_ad_oe}); end
      checks++; if ({m_ad_o, m_tm_o, m_rdata, m_status} !== 68'h0) begin fails++;
         $display("FAIL midreset_data: ad %h tm %b rdata %h status %b want zeros", m_ad_o, m_tm_o, m_rdata, m_status); end
      nub_resetn = 1'b1; seen = 0;
      for (int c = 0; c < 4; c++) begin tick(); if (m_ready) seen++; end
      checks++; if (seen !== 0) begin fails++; $display("FAIL midreset_no_ready: got %0d pulses want 0", seen); end
   endtask

   initial begin
      nub_resetn = 1'b0; valid = 1'b0; sel = 1'b0;
      cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_wstrb = 4'h0; cpu_lock = 1'b0;
      arb_grant = 1'b1; nub_startn_i = 1'b1; nub_ackn_i = 1'b1; nub_tm_i = 2'b00; nub_ad_i = 32'h0;
      test_reset();
      test_word_write();
      test_word_read();
      test_strobes();
      test_timeout();
      test_retry();
      test_back_to_back_lock();
      test_reset_mid_data();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/nubus_master_engine.md
# nubus_master_engine

Synthesizable NuBus master: the initiator side of the slave transaction path. It converts a CPU-side valid/ready request into a single NuBus transfer: request the bus from the card arbiter, drive the start/address cycle, drive or release data, wait for acknowledge, then return read data and NuBus status to the CPU. It sits between the `cpu_*` master port of `nubus` and the NuBus pin drivers; the top level does open-drain inversion and tristating from the `*_oe` outputs.

## Interface
- `TIMEOUT_CLOCKS`, 255: clocks waited for `ACK` after start before aborting.
- `RETRY_MAX`, 3: retries after a try-again-later acknowledge before reporting it.
- `nub_clkn` in 1: the only clock; all flops use its rising edge.
- `nub_resetn` in 1: synchronous, active-low reset.
- `cpu_valid` in 1: request; held until `cpu_ready`.
- `cpu_addr` in 32: byte address; bits [31:2] are used.
- `cpu_wdata` in 32: write data.
- `cpu_wstrb` in 4: byte enables; 0 means a word read.
- `cpu_lock` in 1: keep bus ownership after this transfer.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: read data, valid with `cpu_ready`.
- `cpu_status` out 2: acknowledge status, valid with `cpu_ready`.
- `arb_rqst` out 1: bus request to the arbiter.
- `arb_grant` in 1: arbiter grant.
- `nub_startn_i` in 1: bus START, used for the idle check.
- `nub_ackn_i` in 1: bus ACK, active-low.
- `nub_tm_i` in 2: true-polarity TM[1:0] sampled at ACK.
- `nub_ad_i` in 32: true-polarity AD.
- `nub_startn_o` out 1: START drive, active-low.
- `nub_tm_o` out 2: true-polarity TM drive.
- `nub_tm_oe` out 1: TM output enable.
- `nub_ad_o` out 32: true-polarity AD drive.
- `nub_ad_oe` out 1: AD output enable.

## Operation
- State machine: IDLE → ARB → START → DATA → DONE → IDLE.
- IDLE
  - Wait for `cpu_valid`.
  - Decode `cpu_wstrb`:
    - 0000 → TMAD_RD_WORD
    - 1111 → TMAD_WR_WORD
    - 0011 → TMAD_WR_HALF_0
    - 1100 → TMAD_WR_HALF_1
    - 0001/0010/0100/1000 → TMAD_WR_BYTE_0..3
  - Any other pattern is illegal. Go to DONE with status TMACK_ERROR and no bus cycle.
  - Legal request: latch addr, data, tmad and lock, then go to ARB.
- ARB
  - Assert `arb_rqst`.
  - When `arb_grant`=1 and `nub_startn_i`=1 and `nub_ackn_i`=1, go to START.
  - If bus ownership is already held from a locked transfer, skip ARB and go straight to START.
- START (exactly one cycle)
  - `nub_startn_o`=0.
  - `nub_ad_o` = {addr[31:2], tmad[1:0]}, `nub_ad_oe`=1.
  - `nub_tm_o` = tmad[3:2], `nub_tm_oe`=1.
- DATA
  - `nub_startn_o`=1, `nub_tm_oe`=0.
  - Write (tm[1]=1): `nub_ad_o`=wdata, `nub_ad_oe`=1.
  - Read: `nub_ad_oe`=0.
  - On a cycle with `nub_ackn_i`=0: capture `nub_tm_i` as status and `nub_ad_i` into `cpu_rdata` (reads only), then go to DONE.
  - Timeout counter starts at 0 on entering DATA. If `TIMEOUT_CLOCKS` cycles pass with no ACK: status = TMACK_TIMEOUT, release the bus, go to DONE.
  - Status TMACK_TRYAGAIN with retries < `RETRY_MAX`: increment retry count, drop `arb_rqst` for one cycle, go to ARB. This produces no `cpu_ready`.
- DONE
  - `cpu_ready`=1 for one cycle; all bus outputs released.
  - Go to IDLE.
  - `arb_rqst` stays 1 only if lock is set; otherwise it is 0.
- Write status only; `cpu_rdata` holds its previous value on writes.

## Timing
- Reset values: `cpu_ready`=0, `cpu_rdata`=0, `cpu_status`=TMACK_COMPLETE, `arb_rqst`=0, `nub_startn_o`=1, `nub_tm_o`=0, `nub_ad_o`=0, both `*_oe`=0.
- State is IDLE after reset, with retry and timeout counters cleared.
- Reset mid-transfer releases all bus outputs on the next edge, with no ready pulse.
- Minimum latency, `cpu_valid` sampled to `cpu_ready`, with immediate grant and ACK on the first data cycle: 4 cycles (ARB, START, DATA, DONE).
- Each ACK wait cycle adds one cycle.
- `cpu_valid` is ignored outside IDLE. A new request can be accepted the cycle after DONE.
- If ACK arrives on the same edge the timeout expires, the ACK wins.
- Timeout counter width is clog2(`TIMEOUT_CLOCKS`+1) bits; it saturates and does not wrap.

## Structure
- `nubus_inc.sv` gains the ack-status constants TMACK_COMPLETE, TMACK_ERROR, TMACK_TIMEOUT, TMACK_TRYAGAIN, plus a function `wstrb_to_tmad` built on the existing TMAD_* constants.
- No sub-module. Arbitration stays in the separate card arbiter; this block only raises `arb_rqst`.

## Test plan
- Word write: `cpu_addr`=F0000000, data 87654321, `wstrb`=1111, grant immediate, ACK after 5 clocks.
  - START cycle: `nub_ad_o`=F0000003 (low bits per TMAD_WR_WORD), TM = write word.
  - Data phase: `nub_ad_o`=87654321.
  - `cpu_ready` pulse with status COMPLETE, 9 cycles after valid.
- Word read of F0000004, responder returns 11223344 with ACK on the 2nd data cycle:
  - `nub_ad_oe`=0 during DATA.
  - `cpu_rdata`=11223344 at `cpu_ready`.
- Each byte and halfword strobe pattern → the matching TMAD_WR_* on AD[1:0] and TM.
  - `wstrb`=0101 → no START pulse; `cpu_ready` after 1 cycle with status ERROR.
- No ACK: `cpu_ready` with status TIMEOUT exactly `TIMEOUT_CLOCKS`+1 cycles after START; all `*_oe`=0 afterwards.
- Two TRYAGAIN acknowledges, then COMPLETE → three START pulses and a single `cpu_ready` with status COMPLETE.
  - With `RETRY_MAX`=0, the first TRYAGAIN is reported.
- Locked read followed by a write:
  - `arb_rqst` stays 1 between the two transfers.
  - The second START follows DONE without an ARB state.
- Reset asserted during DATA: outputs at reset values on the next edge; no `cpu_ready`.
